// File: rtl/sha256_block_sequencer_if.sv
// rtl/sha256_block_sequencer_if.sv - block source / round datapath bundle for the SHA-256 sequencer
interface sha256_block_sequencer_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic             blk_valid;
    logic             blk_last;
    logic             blk_ready;
    logic             dp_load;
    logic             dp_round_en;
    logic [IDX_W-1:0] round_idx;
    logic [255:0]     dp_wv;
    logic [255:0]     h_state;
    logic [255:0]     digest;
    logic             digest_valid;
    logic             busy;

    // Block source plus round datapath side
    modport master (
        output start, blk_valid, blk_last, dp_wv,
        input  blk_ready, dp_load, dp_round_en, round_idx,
        input  h_state, digest, digest_valid, busy
    );

    // Sequencer side
    modport slave (
        input  start, blk_valid, blk_last, dp_wv,
        output blk_ready, dp_load, dp_round_en, round_idx,
        output h_state, digest, digest_valid, busy
    );
endinterface

// File: rtl/sha256_block_sequencer.sv
// rtl/sha256_block_sequencer.sv - multi-block SHA-256 compression sequencer and chaining state
module sha256_block_sequencer #(
    parameter int           ROUNDS = 64,
    parameter int           IDX_W  = 6,
    parameter logic [255:0] IV     = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic                      clk,
    input  logic                      rst,
    sha256_block_sequencer_if.slave   bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_BLK = 3'd1;
    localparam logic [2:0] S_ROUND    = 3'd2;
    localparam logic [2:0] S_ADD      = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [IDX_W-1:0] r_round_idx;
    logic             r_last;
    logic [255:0]     r_h;
    logic [255:0]     r_digest;
    logic [255:0]     w_h_fold;
    logic             w_blk_ready;
    logic             w_dp_load;
    logic             w_round_end;

    // Handshake and status decode; everything is a function of state so reset clears it at once
    assign w_blk_ready = (r_state == S_WAIT_BLK);
    assign w_dp_load   = bus.blk_valid & w_blk_ready;
    assign w_round_end = (r_state == S_ROUND) && (r_round_idx == LAST_IDX);

    assign bus.blk_ready    = w_blk_ready;
    assign bus.dp_load      = w_dp_load;
    assign bus.dp_round_en  = (r_state == S_ROUND);
    assign bus.round_idx    = r_round_idx;
    assign bus.h_state      = r_h;
    assign bus.digest       = r_digest;
    assign bus.digest_valid = (r_state == S_DONE);
    assign bus.busy         = (r_state != S_IDLE);

    // Per-word fold of working vars into the chaining value; carries never cross word boundaries
    always_comb begin
        w_h_fold = '0;
        for (int i = 0; i < 8; i++) begin
            w_h_fold[i*32 +: 32] = r_h[i*32 +: 32] + bus.dp_wv[i*32 +: 32];
        end
    end

    // Next-state selection; start is only looked at in IDLE so a running message cannot restart
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.start)  w_state_next = S_WAIT_BLK;
            S_WAIT_BLK: if (w_dp_load)  w_state_next = S_ROUND;
            S_ROUND:    if (w_round_end) w_state_next = S_ADD;
            S_ADD:      w_state_next = r_last ? S_DONE : S_WAIT_BLK;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Round counter: counts through ROUND and returns to 0 on the last round so entry always starts at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round_idx <= '0;
        end else if ((r_state == S_ROUND) && !w_round_end) begin
            r_round_idx <= r_round_idx + 1'b1;
        end else begin
            r_round_idx <= '0;
        end
    end

    // Last-block flag captured only on the accepting handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_dp_load) begin
            r_last <= bus.blk_last;
        end
    end

    // Chaining state: IV on message start, folded sum at the end of every block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_h <= IV;
        end else if (r_state == S_ADD) begin
            r_h <= w_h_fold;
        end
    end

    // Digest takes the final fold directly so it is ready in the DONE cycle and held afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digest <= '0;
        end else if ((r_state == S_ADD) && r_last) begin
            r_digest <= w_h_fold;
        end
    end
endmodule

// File: tb/tb_sha256_block_sequencer.sv
// tb/tb_sha256_block_sequencer.sv - scoreboard bench for sha256_block_sequencer with a reference round datapath
module tb_sha256_block_sequencer;
    localparam logic [255:0] IV_C   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] WRAP_C = 256'h6a09e666_bb67ae84_3c6ef371_a54ff539_510e527e_9b05688b_1f83d9aa_5be0cd18;
    localparam logic [255:0] ABC_C  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_C  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   n_load = 0;
    int   wv_mode = 1;
    logic [511:0] cur_blk = '0;
    logic [511:0] msg_blk [0:1];

    typedef struct {
        logic [255:0] d;
        int           c;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    sha256_block_sequencer_if #(.IDX_W(6)) bus ();

    sha256_block_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference SHA-256 round datapath
    logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [31:0]  m_a, m_b, m_c, m_d, m_e, m_f, m_g, m_h;
    logic [31:0]  m_w [0:63];
    logic [511:0] m_blk;
    logic [31:0]  m_wt, m_t1, m_t2;
    int           m_t;

    always_comb begin
        m_t  = int'(bus.round_idx);
        m_wt = '0;
        if (m_t < 16) begin
            m_wt = m_blk[511 - 32*m_t -: 32];
        end else begin
            m_wt = (ror(m_w[m_t-2], 17) ^ ror(m_w[m_t-2], 19) ^ (m_w[m_t-2] >> 10)) + m_w[m_t-7]
                 + (ror(m_w[m_t-15], 7) ^ ror(m_w[m_t-15], 18) ^ (m_w[m_t-15] >> 3)) + m_w[m_t-16];
        end
        m_t1 = m_h + (ror(m_e, 6) ^ ror(m_e, 11) ^ ror(m_e, 25)) + ((m_e & m_f) ^ (~m_e & m_g)) + K[m_t] + m_wt;
        m_t2 = (ror(m_a, 2) ^ ror(m_a, 13) ^ ror(m_a, 22)) + ((m_a & m_b) ^ (m_a & m_c) ^ (m_b & m_c));
    end

    always @(posedge clk) begin
        if (bus.dp_load) begin
            m_blk <= cur_blk;
            {m_a, m_b, m_c, m_d, m_e, m_f, m_g, m_h} <= bus.h_state;
        end else if (bus.dp_round_en) begin
            m_w[m_t] <= m_wt;
            m_h <= m_g; m_g <= m_f; m_f <= m_e; m_e <= m_d + m_t1;
            m_d <= m_c; m_c <= m_b; m_b <= m_a; m_a <= m_t1 + m_t2;
        end
    end

    always_comb begin
        case (wv_mode)
            0:       bus.dp_wv = {m_a, m_b, m_c, m_d, m_e, m_f, m_g, m_h};
            1:       bus.dp_wv = '0;
            default: bus.dp_wv = '1;
        endcase
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dp_load) n_load <= n_load + 1;
            if (bus.digest_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_digest_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("digest", bus.digest, mon_e.d);
                    chk("digest_cycle", cyc, mon_e.c);
                end
            end
        end
    end

    task automatic run_msg(input int n, input int stall, input int mode, input logic [255:0] exp_d,
                           input bit valid_with_start, input bit poke);
        int k, to, ld0, rc;
        exp_t e;
        wv_mode = mode;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.blk_valid = valid_with_start;
        bus.blk_last = (n == 1);
        cur_blk = msg_blk[0];
        k = cyc;
        e.d = exp_d;
        e.c = k + 67 + (n - 1) * (66 + stall);
        exp_q.push_back(e);
        ld0 = n_load;
        @(negedge clk);
        if (valid_with_start) begin
            chk("idle_start_no_load", bus.dp_load, 0);
            chk("idle_start_no_ready", bus.blk_ready, 0);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.blk_valid = 1'b1;
        for (int b = 0; b < n; b++) begin
            to = 0;
            @(negedge clk);
            while (!bus.dp_load && to < 300) begin
                @(negedge clk);
                to++;
            end
            chk("handshake_seen", bus.dp_load, 1);
            if (b == 0) chk("handshake_cycle", cyc, k + 1);
            @(posedge clk); #1;
            if (b == n - 1) begin
                bus.blk_valid = 1'b0;
                bus.blk_last = 1'b0;
            end else begin
                cur_blk = msg_blk[b+1];
                bus.blk_last = (b + 1 == n - 1);
                if (stall > 0) begin
                    bus.blk_valid = 1'b0;
                    to = 0;
                    @(negedge clk);
                    while (!bus.blk_ready && to < 300) begin
                        @(negedge clk);
                        to++;
                    end
                    rc = bus.blk_ready ? 1 : 0;
                    for (int s = 1; s < stall; s++) begin
                        @(negedge clk);
                        if (bus.blk_ready) rc++;
                    end
                    chk("stall_ready_cycles", rc, stall);
                    @(posedge clk); #1;
                    bus.blk_valid = 1'b1;
                end
            end
        end
        if (poke) begin
            repeat (10) @(posedge clk);
            #1 bus.start = 1'b1;
            @(negedge clk);
            chk("round_en_during_poke", bus.dp_round_en, 1);
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        to = 0;
        @(negedge clk);
        while (!bus.digest_valid && to < 300) begin
            @(negedge clk);
            to++;
        end
        chk("digest_valid_seen", bus.digest_valid, 1);
        if (poke) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_after_done", bus.busy, 0);
        chk("digest_held", bus.digest, exp_d);
        chk("load_count", n_load - ld0, n);
    endtask

    initial begin
        int to;
        bus.start = 1'b0;
        bus.blk_valid = 1'b0;
        bus.blk_last = 1'b0;
        msg_blk[0] = '0;
        msg_blk[1] = '0;
        #3;
        chk("rst_busy", bus.busy, 0);
        chk("rst_h_state", bus.h_state, 0);
        chk("rst_digest", bus.digest, 0);
        chk("rst_round_idx", bus.round_idx, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_msg(1, 0, 1, IV_C, 1'b0, 1'b0);
        run_msg(1, 0, 2, WRAP_C, 1'b0, 1'b0);

        msg_blk[0] = {32'h61626380, 448'h0, 32'h00000018};
        run_msg(1, 0, 0, ABC_C, 1'b1, 1'b1);

        msg_blk[0] = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        msg_blk[1] = {480'h0, 32'h000001c0};
        run_msg(2, 5, 0, TWO_C, 1'b0, 1'b0);

        wv_mode = 1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.blk_last = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.blk_valid = 1'b1;
        to = 0;
        @(negedge clk);
        while (bus.round_idx != 6'd30 && to < 300) begin
            @(negedge clk);
            to++;
        end
        chk("reached_round_30", bus.round_idx, 30);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_blk_ready", bus.blk_ready, 0);
        chk("arst_dp_load", bus.dp_load, 0);
        chk("arst_round_en", bus.dp_round_en, 0);
        chk("arst_round_idx", bus.round_idx, 0);
        chk("arst_h_state", bus.h_state, 0);
        chk("arst_digest", bus.digest, 0);
        chk("arst_digest_valid", bus.digest_valid, 0);
        bus.blk_valid = 1'b0;
        bus.blk_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", bus.busy, 0);

        run_msg(1, 0, 1, IV_C, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
